adc_frame_packetizer: RTL

Downstream consumer of the ADC streaming FIFO. Drains the 32-bit raw word stream (`pop_valid`/`pop_data`/`pop_ready` of the ingest stage), groups words into frames of `WORDS_PER_FRAME`, prepends one header word carrying a magic byte, a 16-bit sequence number and the word count, and sign- or zero-extends each `BITS_PER_WORD` sample to 32 bits. The result is a ready/valid packet stream with an end-of-frame marker, consumed by the Wishbone readout or DMA path.

---
 rtl/adc_frame_packetizer.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/adc_frame_packetizer.sv
`default_nettype none
// ============================================================================
//  Module   : adc_frame_packetizer
//  Purpose  : Drains the raw 32-bit ADC word stream, groups WORDS_PER_FRAME
//             words into a frame, prepends a header word
//             {HDR_MAGIC, seq_num, WORDS_PER_FRAME[7:0]} and sign- or
//             zero-extends each BITS_PER_WORD sample to 32 bits. Output is a
//             registered ready/valid stream with an end-of-frame marker.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk           in   1   rising-edge clock
//    rst_n         in   1   asynchronous active-low reset
//    in_valid_i    in   1   input word available (FIFO pop_valid)
//    in_data_i     in  32   raw input word, sample in [BITS_PER_WORD-1:0]
//    in_ready_o    out  1   input word accepted when in_valid_i && in_ready_o
//    out_valid_o   out  1   output word valid (registered)
//    out_data_o    out 32   header or extended payload word (registered)
//    out_last_o    out  1   final payload word of a frame (registered)
//    out_ready_i   in   1   downstream accepts when out_valid_o && out_ready_i
//    enable_i      in   1   permits starting new frames
//    abort_i       in   1   pulse: abandon the current frame
//    seq_clear_i   in   1   pulse: reset the sequence number
//    seq_num_o     out 16   sequence number the next header will carry
//    busy_o        out  1   frame in progress (payload phase)
//    frame_done_o  out  1   one-cycle pulse after the last payload word loads
// ============================================================================
module adc_frame_packetizer #(
    parameter int unsigned BITS_PER_WORD   = 24,
    parameter int unsigned WORDS_PER_FRAME = 9,
    parameter bit          SIGN_EXTEND     = 1'b1,
    parameter logic [7:0]  HDR_MAGIC       = 8'hA5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid_i,
    input  logic [31:0] in_data_i,
    output logic        in_ready_o,
    output logic        out_valid_o,
    output logic [31:0] out_data_o,
    output logic        out_last_o,
    input  logic        out_ready_i,
    input  logic        enable_i,
    input  logic        abort_i,
    input  logic        seq_clear_i,
    output logic [15:0] seq_num_o,
    output logic        busy_o,
    output logic        frame_done_o
);

    localparam int unsigned          c_cnt_w     = (WORDS_PER_FRAME > 1) ? $clog2(WORDS_PER_FRAME) : 1;
    localparam logic [c_cnt_w-1:0]   c_last_idx  = c_cnt_w'(WORDS_PER_FRAME - 1);
    localparam logic [c_cnt_w-1:0]   c_cnt_one   = c_cnt_w'(1);
    localparam logic [7:0]           c_hdr_count = 8'(WORDS_PER_FRAME);

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_PAYLOAD = 1'b1
    } state_t;

    state_t               state_q;
    logic [c_cnt_w-1:0]   word_cnt_q;
    logic                 out_valid_q;
    logic [31:0]          out_data_q;
    logic                 out_last_q;
    logic [15:0]          seq_num_q;
    logic                 frame_done_q;

    logic                 w_load_ok;
    logic                 w_start;
    logic                 w_in_ready;
    logic                 w_in_hs;
    logic                 w_is_last;
    logic [31:0]          w_ext_data;

    // The output register can take a new word when it is empty or being
    // drained this cycle.
    assign w_load_ok  = !out_valid_q || out_ready_i;

    // in_ready never looks at in_valid_i, so no combinational loop can form
    // with an upstream that waits on ready before raising valid.
    assign w_in_ready = (state_q == ST_PAYLOAD) && w_load_ok && !abort_i;
    assign w_in_hs    = in_valid_i && w_in_ready;

    // The header is only started when a word is waiting, so the payload can
    // follow the header without a bubble. The waiting word is not consumed.
    assign w_start    = (state_q == ST_IDLE) && enable_i && in_valid_i && w_load_ok && !abort_i;
    assign w_is_last  = (word_cnt_q == c_last_idx);

    // Bits above the sample width come either from the sample MSB or zero;
    // a per-bit select also covers BITS_PER_WORD == 32 without a zero-width
    // replication.
    always_comb begin
        w_ext_data = '0;
        for (int i = 0; i < 32; i++) begin
            if (i < int'(BITS_PER_WORD)) begin
                w_ext_data[i] = in_data_i[i];
            end else begin
                w_ext_data[i] = SIGN_EXTEND & in_data_i[BITS_PER_WORD-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            word_cnt_q   <= '0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_last_q   <= 1'b0;
            seq_num_q    <= '0;
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;

            // Output register. Abort blocks both start and handshake, so a
            // word already held is still presented until it is accepted.
            if (w_load_ok) begin
                if (w_start) begin
                    out_valid_q <= 1'b1;
                    out_data_q  <= {HDR_MAGIC, seq_num_q, c_hdr_count};
                    out_last_q  <= 1'b0;
                end else if (w_in_hs) begin
                    out_valid_q <= 1'b1;
                    out_data_q  <= w_ext_data;
                    out_last_q  <= w_is_last;
                end else begin
                    out_valid_q <= 1'b0;
                end
            end

            // Frame sequencing
            if (abort_i) begin
                state_q    <= ST_IDLE;
                word_cnt_q <= '0;
            end else if (w_start) begin
                state_q    <= ST_PAYLOAD;
                word_cnt_q <= '0;
            end else if (w_in_hs) begin
                if (w_is_last) begin
                    state_q      <= ST_IDLE;
                    word_cnt_q   <= '0;
                    frame_done_q <= 1'b1;
                    seq_num_q    <= seq_num_q + 16'd1;
                end else begin
                    word_cnt_q   <= word_cnt_q + c_cnt_one;
                end
            end

            // Clear overrides a coincident end-of-frame increment.
            if (seq_clear_i) begin
                seq_num_q <= '0;
            end
        end
    end

    assign in_ready_o   = w_in_ready;
    assign out_valid_o  = out_valid_q;
    assign out_data_o   = out_data_q;
    assign out_last_o   = out_last_q;
    assign seq_num_o    = seq_num_q;
    assign busy_o       = (state_q == ST_PAYLOAD);
    assign frame_done_o = frame_done_q;

endmodule
`default_nettype wire
